// File: rtl/multi_timed_counter_if.sv
// Bus bundle for multi_timed_counter: event inputs, window control and the per-window readout.
// The master side drives events and window control, and the slave side is the counter itself.
interface multi_timed_counter_if #(
  parameter int NCHAN          = 4,
  parameter int COUNT_WIDTH    = 24,
  parameter int INTERVAL_WIDTH = 24
);
  logic [NCHAN-1:0]             count_in;
  logic [INTERVAL_WIDTH-1:0]    interval_in;
  logic                         interval_load;
  logic                         continuous;
  logic [NCHAN*COUNT_WIDTH-1:0] count_out;
  logic                         count_out_valid;
  logic [NCHAN-1:0]             overflow_out;
  logic [15:0]                  window_index;

  modport master (
    output count_in, interval_in, interval_load, continuous,
    input  count_out, count_out_valid, overflow_out, window_index
  );

  modport slave (
    input  count_in, interval_in, interval_load, continuous,
    output count_out, count_out_valid, overflow_out, window_index
  );
endinterface

// File: rtl/multi_timed_counter.sv
// Multi-channel windowed event counter with saturating per-channel accumulators.
// All channel totals, the overflow flags and the window index publish together on a one-cycle strobe.
module multi_timed_counter #(
  parameter int NCHAN          = 4,
  parameter int COUNT_WIDTH    = 24,
  parameter int INTERVAL_WIDTH = 24
) (
  input logic                  clk,
  input logic                  rst_n,
  multi_timed_counter_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [COUNT_WIDTH-1:0]    MaxCount = '1;
  localparam logic [INTERVAL_WIDTH-1:0] OneTick  = INTERVAL_WIDTH'(1);

  state_e                               state_q;
  logic [INTERVAL_WIDTH-1:0]            interval_q;
  logic [INTERVAL_WIDTH-1:0]            timer_q;
  logic                                 cont_q;
  logic [NCHAN-1:0][COUNT_WIDTH-1:0]    accum_q;
  logic [NCHAN-1:0][COUNT_WIDTH-1:0]    accum_d;
  logic [NCHAN-1:0]                     sat_q;
  logic [NCHAN-1:0]                     sat_d;
  logic [NCHAN-1:0][COUNT_WIDTH-1:0]    countOut_q;
  logic [NCHAN-1:0]                     ovfOut_q;
  logic                                 valid_q;
  logic [15:0]                          index_q;

  // This cycle's events folded into each accumulator. A full accumulator holds its value and raises its sticky flag.
  always_comb begin
    accum_d = accum_q;
    sat_d   = sat_q;
    for (int k = 0; k < NCHAN; k++) begin
      if (bus.count_in[k]) begin
        if (accum_q[k] == MaxCount) begin
          sat_d[k] = 1'b1;
        end else begin
          accum_d[k] = accum_q[k] + COUNT_WIDTH'(1);
        end
      end
    end
  end

  // A load overrides everything, including a terminal cycle, so the interrupted window never strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      interval_q <= '0;
      timer_q    <= '0;
      cont_q     <= 1'b0;
      accum_q    <= '0;
      sat_q      <= '0;
      countOut_q <= '0;
      ovfOut_q   <= '0;
      valid_q    <= 1'b0;
      index_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      if (bus.interval_load) begin
        interval_q <= bus.interval_in;
        cont_q     <= bus.continuous;
        timer_q    <= bus.interval_in - OneTick;
        accum_q    <= '0;
        sat_q      <= '0;
        index_q    <= '0;
        state_q    <= (bus.interval_in != '0) ? RUN : IDLE;
      end else if (state_q == RUN) begin
        if (timer_q == '0) begin
          countOut_q <= accum_d;
          ovfOut_q   <= sat_d;
          valid_q    <= 1'b1;
          index_q    <= index_q + 16'd1;
          accum_q    <= '0;
          sat_q      <= '0;
          timer_q    <= interval_q - OneTick;
          if (!cont_q) begin
            state_q <= IDLE;
          end
        end else begin
          accum_q <= accum_d;
          sat_q   <= sat_d;
          timer_q <= timer_q - OneTick;
        end
      end
    end
  end

  assign bus.count_out       = countOut_q;
  assign bus.overflow_out    = ovfOut_q;
  assign bus.count_out_valid = valid_q;
  assign bus.window_index    = index_q;

endmodule

// File: tb/tb_multi_timed_counter.sv
// Drives a wide counter and a 4-bit saturating counter with identical stimulus.
// Each cycle, both are compared against a window-level reference model.
module tb_multi_timed_counter;

  localparam int NCH = 4;
  localparam int CWA = 24;
  localparam int CWB = 4;
  localparam int IW  = 24;
  localparam int MAXA = (1 << CWA) - 1;
  localparam int MAXB = (1 << CWB) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] countIn;
  logic [IW-1:0]  intervalIn;
  logic           load;
  logic           cont;

  int checks = 0;
  int errors = 0;

  // Reference model: a window is N counted cycles after the load. Totals are plain sums that are clipped when reported.
  bit          running;
  int          mN;
  bit          mCont;
  int          elapsed;
  int          raw[NCH];
  int          expCntA[NCH];
  int          expCntB[NCH];
  logic [NCH-1:0] expOvfA;
  logic [NCH-1:0] expOvfB;
  logic        expValid;
  logic [15:0] expIndex;

  always #5 clk = ~clk;

  multi_timed_counter_if #(.NCHAN(NCH), .COUNT_WIDTH(CWA), .INTERVAL_WIDTH(IW)) busA ();
  multi_timed_counter_if #(.NCHAN(NCH), .COUNT_WIDTH(CWB), .INTERVAL_WIDTH(IW)) busB ();

  assign busA.count_in      = countIn;
  assign busA.interval_in   = intervalIn;
  assign busA.interval_load = load;
  assign busA.continuous    = cont;
  assign busB.count_in      = countIn;
  assign busB.interval_in   = intervalIn;
  assign busB.interval_load = load;
  assign busB.continuous    = cont;

  multi_timed_counter #(.NCHAN(NCH), .COUNT_WIDTH(CWA), .INTERVAL_WIDTH(IW)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(busA)
  );
  multi_timed_counter #(.NCHAN(NCH), .COUNT_WIDTH(CWB), .INTERVAL_WIDTH(IW)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(busB)
  );

  task automatic modelReset();
    running  = 1'b0;
    mN       = 0;
    mCont    = 1'b0;
    elapsed  = 0;
    expValid = 1'b0;
    expIndex = '0;
    expOvfA  = '0;
    expOvfB  = '0;
    for (int k = 0; k < NCH; k++) begin
      raw[k]     = 0;
      expCntA[k] = 0;
      expCntB[k] = 0;
    end
  endtask

  task automatic modelStep();
    expValid = 1'b0;
    if (load) begin
      running  = (intervalIn != '0);
      mN       = int'(intervalIn);
      mCont    = cont;
      elapsed  = 0;
      expIndex = '0;
      for (int k = 0; k < NCH; k++) raw[k] = 0;
    end else if (running) begin
      elapsed++;
      for (int k = 0; k < NCH; k++) raw[k] += int'(countIn[k]);
      if (elapsed == mN) begin
        expValid = 1'b1;
        expIndex = expIndex + 16'd1;
        for (int k = 0; k < NCH; k++) begin
          expCntA[k] = (raw[k] > MAXA) ? MAXA : raw[k];
          expCntB[k] = (raw[k] > MAXB) ? MAXB : raw[k];
          expOvfA[k] = (raw[k] > MAXA);
          expOvfB[k] = (raw[k] > MAXB);
          raw[k]     = 0;
        end
        elapsed = 0;
        running = mCont;
      end
    end
  endtask

  task automatic check1(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [NCH*CWA-1:0] vecA;
    logic [NCH*CWB-1:0] vecB;
    for (int k = 0; k < NCH; k++) begin
      vecA[k*CWA +: CWA] = CWA'(expCntA[k]);
      vecB[k*CWB +: CWB] = CWB'(expCntB[k]);
    end
    check1("validA", 128'(busA.count_out_valid), 128'(expValid));
    check1("validB", 128'(busB.count_out_valid), 128'(expValid));
    check1("countA", 128'(busA.count_out), 128'(vecA));
    check1("countB", 128'(busB.count_out), 128'(vecB));
    check1("ovfA", 128'(busA.overflow_out), 128'(expOvfA));
    check1("ovfB", 128'(busB.overflow_out), 128'(expOvfB));
    check1("indexA", 128'(busA.window_index), 128'(expIndex));
    check1("indexB", 128'(busB.window_index), 128'(expIndex));
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] ci, input bit ld, input int n, input bit c);
    countIn    = ci;
    load       = ld;
    intervalIn = IW'(n);
    cont       = c;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic loadWindow(input int n, input bit c);
    applyStimulus(NCH'($urandom), 1'b1, n, c);
  endtask

  // Random events with some channels forced high and others forced low.
  task automatic runCycles(input int cycles, input logic [NCH-1:0] force1, input logic [NCH-1:0] force0);
    logic [NCH-1:0] ci;
    for (int i = 0; i < cycles; i++) begin
      ci = (NCH'($urandom) | force1) & ~force0;
      applyStimulus(ci, 1'b0, 0, 1'b0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    countIn    = '0;
    intervalIn = '0;
    load       = 1'b0;
    cont       = 1'b0;
    modelReset();
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    rst_n = 1'b1;

    $display("[TB] ch0 burst of 10 in a 50-cycle continuous window");
    applyStimulus('0, 1'b1, 50, 1'b1);
    for (int i = 0; i < 60; i++) applyStimulus((i >= 3 && i < 13) ? 4'b0001 : 4'b0000, 1'b0, 0, 1'b0);

    $display("[TB] ch1 held high over back-to-back windows");
    loadWindow(50, 1'b1);
    runCycles(155, 4'b0010, 4'b0000);

    $display("[TB] ch2 saturation then a clean window");
    loadWindow(20, 1'b1);
    runCycles(20, 4'b0100, 4'b0000);
    runCycles(22, 4'b0000, 4'b0100);

    $display("[TB] single-shot N=8 then idle");
    loadWindow(8, 1'b0);
    runCycles(8, 4'b1000, 4'b0000);
    runCycles(110, 4'b0000, 4'b0000);

    $display("[TB] reload mid-window");
    loadWindow(50, 1'b1);
    runCycles(24, 4'b0000, 4'b0000);
    loadWindow(30, 1'b1);
    runCycles(65, 4'b0000, 4'b0000);

    $display("[TB] N=1 continuous");
    loadWindow(1, 1'b1);
    runCycles(10, 4'b0000, 4'b0000);

    $display("[TB] load on the terminal cycle");
    loadWindow(5, 1'b1);
    runCycles(4, 4'b0000, 4'b0000);
    loadWindow(7, 1'b1);
    runCycles(20, 4'b0000, 4'b0000);

    $display("[TB] zero-length load disables counting");
    loadWindow(10, 1'b1);
    runCycles(5, 4'b0000, 4'b0000);
    loadWindow(0, 1'b1);
    runCycles(30, 4'b1111, 4'b0000);

    $display("[TB] random loads and events");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) loadWindow(int'($urandom_range(0, 40)), 1'($urandom));
      else runCycles(1, 4'b0000, 4'b0000);
    end

    $display("[TB] asynchronous reset mid-window");
    loadWindow(12, 1'b1);
    runCycles(30, 4'b0000, 4'b0000);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    rst_n = 1'b1;
    runCycles(80, 4'b1111, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
